seven_seg_capture: RTL



---
 rtl/seven_seg_pkg.sv | 29 ++
 rtl/seven_seg_capture_if.sv | 21 ++
 rtl/seven_seg_pattern_decode.sv | 40 ++++
 rtl/seven_seg_capture.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns (bit 6 = g ... bit 0 = a)
// and the capture FSM state type.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        SCAN,
        CONV,
        OUT
    } cap_state_t;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Result channel of the seven-segment capture block: valid/ready plus the decoded frame.
interface seven_seg_capture_if #(
    parameter int NDIGITS = 2
);
    logic                   out_val;
    logic                   out_rdy;
    logic [4*NDIGITS-1:0]   out_digits;
    logic [4*NDIGITS-1:0]   out_bin;
    logic                   out_err;
    logic                   out_hex;

    modport master (
        output out_val, out_digits, out_bin, out_err, out_hex,
        input  out_rdy
    );

    modport slave (
        input  out_val, out_digits, out_bin, out_err, out_hex,
        output out_rdy
    );
endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Combinational active-low segment pattern to digit decoder.
// SEVEN_SEG_CAPTURE_HEX_EN adds the A-F letter patterns as valid digits 10-15.
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       invalid
);

    always_comb begin
        digit   = 4'hF;
        invalid = 1'b0;
        case (pattern)
            SEG_0: digit = 4'd0;
            SEG_1: digit = 4'd1;
            SEG_2: digit = 4'd2;
            SEG_3: digit = 4'd3;
            SEG_4: digit = 4'd4;
            SEG_5: digit = 4'd5;
            SEG_6: digit = 4'd6;
            SEG_7: digit = 4'd7;
            SEG_8: digit = 4'd8;
            SEG_9: digit = 4'd9;
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
            SEG_A: digit = 4'hA;
            SEG_B: digit = 4'hB;
            SEG_C: digit = 4'hC;
            SEG_D: digit = 4'hD;
            SEG_E: digit = 4'hE;
            SEG_F: digit = 4'hF;
`endif
            default: begin
                digit   = 4'hF;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Reads a multiplexed active-low seven-segment bus back into digits and a binary value.
// Optional build macro: SEVEN_SEG_CAPTURE_HEX_EN (accept A-F, radix-16 result for hex frames).
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NDIGITS       = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg,
    input  logic [NDIGITS-1:0]   dig_en,
    seven_seg_capture_if.master  res
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [6:0]         seg_reg, seg_prev_reg;
    logic [NDIGITS-1:0] dig_reg, dig_prev_reg;
    logic [CW-1:0]      cnt_reg, cnt_next;

    cap_state_t         state_reg;
    logic [NDIGITS-1:0] seen_reg;
    logic [W-1:0]       slot_dig_reg, slot_dig_next;
    logic [NDIGITS-1:0] slot_inv_reg, slot_inv_next;
    logic [W-1:0]       acc_reg;
    logic [IW-1:0]      idx_reg;

    logic               val_reg;
    logic [W-1:0]       digits_reg;
    logic [W-1:0]       bin_reg;
    logic               err_reg;
    logic               hex_reg;

    logic [3:0]         pat_digit;
    logic               pat_invalid;
    logic               dig_onehot;
    logic               stable;
    logic               latch;
    logic [NDIGITS-1:0] seen_set;
    logic               frame_full;
    logic [3:0]         cur_digit;
    logic [W-1:0]       acc_mul;
    logic [W-1:0]       acc_next;
    logic               any_inv;
    logic               any_hex;

    seven_seg_pattern_decode u_decode (
        .pattern (seg_reg),
        .digit   (pat_digit),
        .invalid (pat_invalid)
    );

    // The counter only runs while scanning, which is also how CONV/OUT ignore the bus.
    assign dig_onehot = (dig_reg != '0) && ((dig_reg & (dig_reg - 1'b1)) == '0);
    assign stable     = (state_reg == SCAN) && dig_onehot &&
                        (seg_reg == seg_prev_reg) && (dig_reg == dig_prev_reg);
    assign latch      = stable && (cnt_reg == CW'(STABLE_CYCLES - 2));
    assign seen_set   = latch ? dig_reg : '0;
    assign frame_full = &(seen_reg | seen_set);

    always_comb begin
        cnt_next = '0;
        if (stable) begin
            cnt_next = (cnt_reg == CW'(STABLE_CYCLES)) ? cnt_reg : cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_slot
            assign slot_dig_next[4*gi +: 4] = (latch && dig_reg[gi]) ? pat_digit
                                                                     : slot_dig_reg[4*gi +: 4];
            assign slot_inv_next[gi]        = (latch && dig_reg[gi]) ? pat_invalid
                                                                     : slot_inv_reg[gi];
        end
    endgenerate

`ifdef SEVEN_SEG_CAPTURE_HEX_EN
    logic [NDIGITS-1:0] hex_bits;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_hex
            assign hex_bits[gi] = !slot_inv_reg[gi] && (slot_dig_reg[4*gi +: 4] > 4'd9);
        end
    endgenerate
    assign any_hex = |hex_bits;
`else
    assign any_hex = 1'b0;
`endif

    assign any_inv   = |slot_inv_reg;
    assign cur_digit = slot_dig_reg[4*idx_reg +: 4];
    assign acc_mul   = acc_reg * W'(10);
    assign acc_next  = acc_mul + W'(cur_digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg      <= '0;
            dig_reg      <= '0;
            seg_prev_reg <= '0;
            dig_prev_reg <= '0;
            cnt_reg      <= '0;
            slot_dig_reg <= '0;
            slot_inv_reg <= '0;
        end else begin
            seg_reg      <= seg;
            dig_reg      <= dig_en;
            seg_prev_reg <= seg_reg;
            dig_prev_reg <= dig_reg;
            cnt_reg      <= cnt_next;
            slot_dig_reg <= slot_dig_next;
            slot_inv_reg <= slot_inv_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= SCAN;
            seen_reg   <= '0;
            acc_reg    <= '0;
            idx_reg    <= IW'(NDIGITS - 1);
            val_reg    <= 1'b0;
            digits_reg <= '0;
            bin_reg    <= '0;
            err_reg    <= 1'b0;
            hex_reg    <= 1'b0;
        end else begin
            case (state_reg)
                SCAN: begin
                    seen_reg <= seen_reg | seen_set;
                    if (frame_full) begin
                        state_reg <= CONV;
                        acc_reg   <= '0;
                        idx_reg   <= IW'(NDIGITS - 1);
                    end
                end
                CONV: begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg - 1'b1;
                    if (idx_reg == '0) begin
                        state_reg  <= OUT;
                        val_reg    <= 1'b1;
                        digits_reg <= slot_dig_reg;
                        err_reg    <= any_inv;
                        hex_reg    <= any_hex && !any_inv;
                        // Error frames report zero; hex frames report the raw nibbles.
                        if (any_inv) begin
                            bin_reg <= '0;
                        end else if (any_hex) begin
                            bin_reg <= slot_dig_reg;
                        end else begin
                            bin_reg <= acc_next;
                        end
                    end
                end
                OUT: begin
                    if (res.out_rdy) begin
                        val_reg   <= 1'b0;
                        seen_reg  <= '0;
                        state_reg <= SCAN;
                    end
                end
                default: state_reg <= SCAN;
            endcase
        end
    end

    assign res.out_val    = val_reg;
    assign res.out_digits = digits_reg;
    assign res.out_bin    = bin_reg;
    assign res.out_err    = err_reg;
    assign res.out_hex    = hex_reg;

endmodule
